uart_rx_ctrl: RTL and testbench

Receive-side controller between the `uart_rx` deserializer and the host read interface.
- Owns the receiver's frame configuration and applies changes only between frames.
- Buffers received bytes, each with its parity-error flag, in a FIFO.
- Drives `cts_n` flow control with hysteresis, and handles flush and overrun.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 73 +++++++
 rtl/uart_rx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side control path.
// Frame configuration layout, its reset value and controller states.
package uart_pkg;

  typedef struct packed {
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
  } uart_cfg_t;

  localparam uart_cfg_t UART_CFG_RST = '{
    data_bit_num: 2'b11,
    stop_bit_num: 1'b0,
    parity_en:    1'b0,
    parity_type:  1'b0
  };

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DISCARD
  } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO for received bytes plus parity flag.
// Flush wins over push/pop; a push at full is taken only with a pop.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: frame tracking, shadowed configuration,
// received-byte FIFO, cts_n hysteresis and sticky overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CTS_HI = DEPTH - 4,
  parameter int CTS_LO = DEPTH / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic                   rx_done,
  input  logic [7:0]             rx_data,
  input  logic                   parity_error,
  input  logic                   cfg_wr,
  input  logic [1:0]             cfg_data_bit_num,
  input  logic                   cfg_stop_bit_num,
  input  logic                   cfg_parity_en,
  input  logic                   cfg_parity_type,
  output logic [1:0]             data_bit_num,
  output logic                   stop_bit_num,
  output logic                   parity_en,
  output logic                   parity_type,
  output logic                   cfg_pending,
  input  logic                   flush,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [7:0]             rd_data,
  output logic                   rd_perr,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   cts_n,
  output logic                   overrun,
  input  logic                   err_clr,
  output logic                   busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HI = CW'(CTS_HI);
  localparam logic [CW-1:0] LO = CW'(CTS_LO);

  rx_ctrl_state_t state_q, state_d;
  uart_cfg_t      shadow_q, shadow_d;
  uart_cfg_t      active_q, active_d;
  uart_cfg_t      cfg_in;
  logic           pending_q, pending_d;
  logic           cts_q, cts_d;
  logic           ovr_q, ovr_d;

  logic           push_req;
  logic           pop_ok;
  logic           push_ok;
  logic           apply;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic [CW-1:0]  cnt_nxt;
  logic [8:0]     dout;

  assign cfg_in = '{
    data_bit_num: cfg_data_bit_num,
    stop_bit_num: cfg_stop_bit_num,
    parity_en:    cfg_parity_en,
    parity_type:  cfg_parity_type
  };

  assign push_req = rx_done && (state_q != DISCARD);
  assign pop_ok   = rd_ready && !empty && !flush;
  assign push_ok  = push_req && !flush && (!full || pop_ok);
  assign apply    = (state_q == IDLE) && rx && pending_q && !cfg_wr;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   ({parity_error, rx_data}),
    .pop   (rd_ready),
    .flush (flush),
    .full  (full),
    .empty (empty),
    .count (count),
    .dout  (dout)
  );

  always_comb begin
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_nxt = count + CW'(1);
        2'b01:   cnt_nxt = count - CW'(1);
        default: cnt_nxt = count;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!rx) state_d = FRAME;
      FRAME: begin
        if (rx_done)    state_d = IDLE;
        else if (flush) state_d = DISCARD;
      end
      DISCARD: if (rx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (cfg_wr) begin
      shadow_d  = cfg_in;
      pending_d = 1'b1;
    end else if (apply) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    cts_d = cts_q;
    ovr_d = ovr_q;
    if (cnt_nxt >= HI)      cts_d = 1'b1;
    else if (cnt_nxt <= LO) cts_d = 1'b0;
    // Set wins over clear.
    if (push_req && !flush && full && !pop_ok) ovr_d = 1'b1;
    else if (err_clr)                         ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= UART_CFG_RST;
      active_q  <= UART_CFG_RST;
      pending_q <= 1'b0;
      cts_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cts_q     <= cts_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_bit_num = active_q.data_bit_num;
  assign stop_bit_num = active_q.stop_bit_num;
  assign parity_en    = active_q.parity_en;
  assign parity_type  = active_q.parity_type;
  assign cfg_pending  = pending_q;
  assign rd_valid     = !empty;
  assign rd_data      = dout[7:0];
  assign rd_perr      = dout[8];
  assign fifo_count   = count;
  assign cts_n        = cts_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scenario bench for uart_rx_ctrl with DEPTH=8, CTS_HI=6, CTS_LO=4.
// Expected FIFO entries are queued on push and compared on pop.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          parity_error = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_data_bit_num = '0;
  logic          cfg_stop_bit_num = 1'b0;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_type = 1'b0;
  logic [1:0]    data_bit_num;
  logic          stop_bit_num;
  logic          parity_en;
  logic          parity_type;
  logic          cfg_pending;
  logic          flush = 1'b0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic [CW-1:0] fifo_count;
  logic          cts_n;
  logic          overrun;
  logic          err_clr = 1'b0;
  logic          busy;

  logic [8:0] sb [$];
  int mcnt  = 0;
  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(
    .DEPTH  (8),
    .CTS_HI (6),
    .CTS_LO (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx               (rx),
    .rx_done          (rx_done),
    .rx_data          (rx_data),
    .parity_error     (parity_error),
    .cfg_wr           (cfg_wr),
    .cfg_data_bit_num (cfg_data_bit_num),
    .cfg_stop_bit_num (cfg_stop_bit_num),
    .cfg_parity_en    (cfg_parity_en),
    .cfg_parity_type  (cfg_parity_type),
    .data_bit_num     (data_bit_num),
    .stop_bit_num     (stop_bit_num),
    .parity_en        (parity_en),
    .parity_type      (parity_type),
    .cfg_pending      (cfg_pending),
    .flush            (flush),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .rd_perr          (rd_perr),
    .fifo_count       (fifo_count),
    .cts_n            (cts_n),
    .overrun          (overrun),
    .err_clr          (err_clr),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // All helpers start and end on a falling edge.
  task automatic push_b(input logic [7:0] d, input logic pe);
    rx_done      = 1'b1;
    rx_data      = d;
    parity_error = pe;
    if (mcnt < DEPTH) begin
      sb.push_back({pe, d});
      mcnt++;
    end
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pop_one(output logic [8:0] got, output logic v);
    got      = {rd_perr, rd_data};
    v        = rd_valid;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    if (v) mcnt--;
  endtask

  task automatic start_frame();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if (fifo_count !== 4'd0) begin
      bad++; $display("FAIL rst_count: got %0d want 0", fifo_count);
    end
    total++;
    if ({rd_valid, cts_n, overrun, busy, cfg_pending} !== 5'b0) begin
      bad++;
      $display("FAIL rst_flags: got %b want 00000",
               {rd_valid, cts_n, overrun, busy, cfg_pending});
    end
    total++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type} !== 5'b11000) begin
      bad++;
      $display("FAIL rst_cfg: got %b want 11000",
               {data_bit_num, stop_bit_num, parity_en, parity_type});
    end
  endtask

  task automatic test_push_pop();
    logic [8:0] got, e;
    logic v;
    start_frame();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL pp_busy: got %b want 1", busy);
    end
    @(negedge clk);
    push_b(8'h41, 1'b0);
    start_frame();
    @(negedge clk);
    push_b(8'h42, 1'b1);
    total++;
    if (fifo_count !== 4'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pp_count: got %0d/%b want 2/0", fifo_count, busy);
    end
    for (int i = 0; i < 2; i++) begin
      pop_one(got, v);
      e = sb.pop_front();
      total++;
      if (got !== e || v !== 1'b1) begin
        bad++; $display("FAIL pp_data%0d: got %h/%b want %h/1", i, got, v, e);
      end
    end
    total++;
    if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin
      bad++;
      $display("FAIL pp_empty: got %b/%0d want 0/0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_cts();
    logic [8:0] got, e;
    logic v;
    for (int i = 0; i < 6; i++) begin
      push_b(8'h10 + 8'(i), 1'(i));
      total++;
      if (cts_n !== (i == 5)) begin
        bad++; $display("FAIL cts_up%0d: got %b want %b", i, cts_n, (i == 5));
      end
    end
    for (int i = 0; i < 6; i++) begin
      pop_one(got, v);
      e = sb.pop_front();
      total++;
      if (got !== e || v !== 1'b1) begin
        bad++; $display("FAIL cts_data%0d: got %h want %h", i, got, e);
      end
      total++;
      if (fifo_count !== CW'(5 - i) || cts_n !== (i == 0)) begin
        bad++;
        $display("FAIL cts_dn%0d: got %0d/%b want %0d/%b",
                 i, fifo_count, cts_n, 5 - i, (i == 0));
      end
    end
  endtask

  task automatic test_overrun();
    logic [8:0] got, e;
    logic v;
    for (int i = 0; i < 8; i++) push_b(8'h80 + 8'(i), 1'b0);
    total++;
    if (fifo_count !== 4'd8 || overrun !== 1'b0 || cts_n !== 1'b1) begin
      bad++;
      $display("FAIL ovr_fill: got %0d/%b/%b want 8/0/1",
               fifo_count, overrun, cts_n);
    end
    push_b(8'h99, 1'b0);
    total++;
    if (fifo_count !== 4'd8 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set: got %0d/%b want 8/1", fifo_count, overrun);
    end
    got = {rd_perr, rd_data};
    e   = sb.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL ovr_head: got %h want %h", got, e);
    end
    rx_done      = 1'b1;
    rx_data      = 8'hA5;
    parity_error = 1'b1;
    rd_ready     = 1'b1;
    sb.push_back(9'h1A5);
    @(negedge clk);
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    total++;
    if (fifo_count !== 4'd8) begin
      bad++; $display("FAIL ovr_pushpop: got %0d want 8", fifo_count);
    end
    err_clr = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'h77;
    @(negedge clk);
    rx_done = 1'b0;
    err_clr = 1'b0;
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_setwins: got %b want 1", overrun);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_clr: got %b want 0", overrun);
    end
    for (int i = 0; i < 8; i++) begin
      pop_one(got, v);
      e = sb.pop_front();
      total++;
      if (got !== e || v !== 1'b1) begin
        bad++; $display("FAIL ovr_drain%0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_cfg();
    logic [8:0] got, e;
    logic v;
    start_frame();
    cfg_wr           = 1'b1;
    cfg_data_bit_num = 2'd0;
    cfg_parity_en    = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cfg_pending !== 1'b1 || data_bit_num !== 2'd3 || parity_en !== 1'b0) begin
      bad++;
      $display("FAIL cfg_hold: got %b/%0d/%b want 1/3/0",
               cfg_pending, data_bit_num, parity_en);
    end
    push_b(8'h3C, 1'b0);
    total++;
    if (cfg_pending !== 1'b1 || data_bit_num !== 2'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cfg_idle: got %b/%0d/%b want 1/3/0",
               cfg_pending, data_bit_num, busy);
    end
    @(negedge clk);
    total++;
    if (cfg_pending !== 1'b0 || data_bit_num !== 2'd0 || parity_en !== 1'b1) begin
      bad++;
      $display("FAIL cfg_apply: got %b/%0d/%b want 0/0/1",
               cfg_pending, data_bit_num, parity_en);
    end
    pop_one(got, v);
    e = sb.pop_front();
    total++;
    if (got !== e || v !== 1'b1) begin
      bad++; $display("FAIL cfg_data: got %h want %h", got, e);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_b(8'h20 + 8'(i), 1'b0);
    start_frame();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    mcnt = 0;
    total++;
    if (fifo_count !== 4'd0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL fl_clear: got %0d/%b/%b want 0/0/1",
               fifo_count, rd_valid, busy);
    end
    rx_done = 1'b1;
    rx_data = 8'h55;
    @(negedge clk);
    rx_done = 1'b0;
    total++;
    if (fifo_count !== 4'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL fl_drop: got %0d/%b/%b want 0/0/0",
               fifo_count, busy, overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got, e;
    logic v;
    for (int i = 0; i < 6; i++) push_b(8'h60 + 8'(i), 1'b1);
    start_frame();
    cfg_wr           = 1'b1;
    cfg_data_bit_num = 2'd1;
    cfg_stop_bit_num = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    total++;
    if (cfg_pending !== 1'b1 || busy !== 1'b1 || cts_n !== 1'b1) begin
      bad++;
      $display("FAIL rm_pre: got %b/%b/%b want 1/1/1", cfg_pending, busy, cts_n);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (fifo_count !== 4'd0 || cts_n !== 1'b0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rm_fifo: got %0d/%b/%b want 0/0/0",
               fifo_count, cts_n, rd_valid);
    end
    total++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_pending, busy}
        !== 7'b1100000) begin
      bad++;
      $display("FAIL rm_cfg: got %b want 1100000",
               {data_bit_num, stop_bit_num, parity_en, parity_type,
                cfg_pending, busy});
    end
    sb.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_b(8'h5A, 1'b1);
    total++;
    if (fifo_count !== 4'd1) begin
      bad++; $display("FAIL rm_spur: got %0d want 1", fifo_count);
    end
    pop_one(got, v);
    e = sb.pop_front();
    total++;
    if (got !== e || v !== 1'b1) begin
      bad++; $display("FAIL rm_data: got %h want %h", got, e);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_push_pop();
    test_cts();
    test_overrun();
    test_cfg();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
